// File: rtl/fpu_sched_pkg.sv
// FPU issue scheduler shared types, widths and defaults.
// Imported by the interface, the writeback slot ring and the top.
package fpu_sched_pkg;

    localparam int MAX_LAT_D   = 6;
    localparam int FWD_SLACK_D = 1;
    localparam int REG_IDX_W   = 5;
    localparam int LAT_W       = 3;
    localparam int NREG        = 1 << REG_IDX_W;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [LAT_W-1:0]     lat_t;

    // A latency is usable only if it lands inside the slot ring.
    function automatic logic lat_legal(lat_t lat, int max_lat);
        return (lat != '0) && (int'(lat) <= max_lat);
    endfunction

endpackage

// File: rtl/fpu_issue_sched_if.sv
// Issue handshake between the FPU decode stage and the scheduler.
// master: decode drives the offer; slave: scheduler answers stall/fire.
interface fpu_issue_sched_if;

    import fpu_sched_pkg::*;

    logic     issue_valid;
    reg_idx_t issue_rs1;
    reg_idx_t issue_rs2;
    reg_idx_t issue_rs3;
    logic     use_rs1;
    logic     use_rs2;
    logic     use_rs3;
    logic     issue_wr;
    reg_idx_t issue_rd;
    lat_t     issue_lat;
    logic     stall;
    logic     issue_fire;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs3,
        output use_rs1, use_rs2, use_rs3,
        output issue_wr, issue_rd, issue_lat,
        input  stall, issue_fire
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs3,
        input  use_rs1, use_rs2, use_rs3,
        input  issue_wr, issue_rd, issue_lat,
        output stall, issue_fire
    );

endinterface

// File: rtl/fpu_wb_slot.sv
// Writeback reservation ring: resv[k] means a write lands k cycles out.
// Ports: set/set_lat/set_rd reserve, query_lat -> conflict, wb_* / inflight out.
module fpu_wb_slot
    import fpu_sched_pkg::*;
#(
    parameter int MAX_LAT = MAX_LAT_D
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     clken,
    input  logic     flush,
    input  logic     set,
    input  lat_t     set_lat,
    input  reg_idx_t set_rd,
    input  lat_t     query_lat,
    output logic     conflict,
    output logic     wb_valid,
    output reg_idx_t wb_rd,
    output lat_t     inflight
);

    logic [MAX_LAT:0] resv_q;
    logic [MAX_LAT:0] resv_d;
    reg_idx_t         slot_q [MAX_LAT+1];
    reg_idx_t         slot_d [MAX_LAT+1];
    lat_t             pop_d;

    // Out-of-range latencies never match a slot, so they never conflict.
    always_comb begin
        conflict = 1'b0;
        for (int k = 0; k <= MAX_LAT; k++) begin
            if (query_lat == lat_t'(k)) begin
                conflict = resv_q[k];
            end
        end
    end

    // A write with latency L must be at slot L-1 after this edge so
    // that it reaches slot 0 exactly L cycles after acceptance.
    always_comb begin
        resv_d = resv_q >> 1;
        for (int k = 0; k < MAX_LAT; k++) begin
            slot_d[k] = slot_q[k+1];
        end
        slot_d[MAX_LAT] = '0;
        if (set) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                if (set_lat == lat_t'(k + 1)) begin
                    resv_d[k] = 1'b1;
                    slot_d[k] = set_rd;
                end
            end
        end
        if (flush) begin
            resv_d = '0;
            for (int k = 0; k <= MAX_LAT; k++) begin
                slot_d[k] = '0;
            end
        end
        pop_d = '0;
        for (int k = 0; k < MAX_LAT; k++) begin
            pop_d = pop_d + lat_t'(resv_d[k]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resv_q   <= '0;
            inflight <= '0;
            for (int k = 0; k <= MAX_LAT; k++) begin
                slot_q[k] <= '0;
            end
        end else if (clken) begin
            resv_q   <= resv_d;
            inflight <= pop_d;
            for (int k = 0; k <= MAX_LAT; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    assign wb_valid = resv_q[0];
    assign wb_rd    = slot_q[0];

endmodule

// File: rtl/fpu_issue_sched.sv
// FPU issue scheduler: per-register busy counters, hazard stall, slot ring.
// Ports: clk/rstn/clken/flush, iss (issue handshake), lat_err, wb_*, busy_mask, inflight.
module fpu_issue_sched
    import fpu_sched_pkg::*;
#(
    parameter int MAX_LAT   = MAX_LAT_D,
    parameter int FWD_SLACK = FWD_SLACK_D
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clken,
    input  logic             flush,
    fpu_issue_sched_if.slave iss,
    output logic             lat_err,
    output logic             wb_valid,
    output reg_idx_t         wb_rd,
    output logic [NREG-1:0]  busy_mask,
    output lat_t             inflight
);

    localparam lat_t SLACK = lat_t'(FWD_SLACK);

    lat_t            cnt_q [NREG];
    lat_t            cnt_d [NREG];
    logic [NREG-1:0] busy_d;

    logic lat_ok;
    logic src_haz;
    logic waw;
    logic port_busy;
    logic wr_haz;
    logic stall_c;
    logic fire;
    logic load;
    logic bad_lat;

    // Sources whose producer is at most FWD_SLACK cycles away are
    // covered by forwarding. WAW keeps writebacks to one register ordered.
    always_comb begin
        lat_ok  = lat_legal(iss.issue_lat, MAX_LAT);
        src_haz = (iss.use_rs1 && (cnt_q[iss.issue_rs1] > SLACK))
               || (iss.use_rs2 && (cnt_q[iss.issue_rs2] > SLACK))
               || (iss.use_rs3 && (cnt_q[iss.issue_rs3] > SLACK));
        waw     = cnt_q[iss.issue_rd] > iss.issue_lat;
        wr_haz  = iss.issue_wr && (port_busy || waw);
        stall_c = iss.issue_valid && (src_haz || wr_haz);
        fire    = iss.issue_valid && !stall_c && clken && !flush;
        load    = fire && iss.issue_wr && lat_ok;
        bad_lat = fire && iss.issue_wr && !lat_ok;
    end

    assign iss.stall      = stall_c;
    assign iss.issue_fire = fire;

    // A fresh load replaces the decrement on its own register.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (load && (iss.issue_rd == reg_idx_t'(i))) begin
                cnt_d[i] = iss.issue_lat;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - lat_t'(1);
            end
            busy_d[i] = cnt_d[i] != '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_mask <= '0;
            lat_err   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (clken) begin
            busy_mask <= busy_d;
            lat_err   <= bad_lat;
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    fpu_wb_slot #(
        .MAX_LAT (MAX_LAT)
    ) u_wb_slot (
        .clk       (clk),
        .rstn      (rstn),
        .clken     (clken),
        .flush     (flush),
        .set       (load),
        .set_lat   (iss.issue_lat),
        .set_rd    (iss.issue_rd),
        .query_lat (iss.issue_lat),
        .conflict  (port_busy),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .inflight  (inflight)
    );

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Bench for fpu_issue_sched: directed scenarios with literal expectations,
// then random traffic checked each cycle against a pending-write list model.
module tb_fpu_issue_sched;

    import fpu_sched_pkg::*;

    localparam int ML = MAX_LAT_D;
    localparam int FS = FWD_SLACK_D;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clken;
    logic        flush;
    logic        lat_err;
    logic        wb_valid;
    reg_idx_t    wb_rd;
    logic [31:0] busy_mask;
    lat_t        inflight;

    int tests;
    int fails;
    bit chk_on = 1'b0;

    fpu_issue_sched_if ifc ();

    fpu_issue_sched #(
        .MAX_LAT   (ML),
        .FWD_SLACK (FS)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clken     (clken),
        .flush     (flush),
        .iss       (ifc),
        .lat_err   (lat_err),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .busy_mask (busy_mask),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    // Model: list of pending writes, rem = cycles until it lands.
    typedef struct {
        int rem;
        int rd;
    } pend_t;

    pend_t pend [$];
    bit    lat_err_m = 1'b0;

    function automatic int cnt_of(int r);
        int c = 0;
        foreach (pend[i]) begin
            if (pend[i].rd == r && pend[i].rem + 1 > c) c = pend[i].rem + 1;
        end
        return c;
    endfunction

    function automatic bit m_stall();
        bit s = 1'b0;
        int L = int'(ifc.issue_lat);
        if (!ifc.issue_valid) return 1'b0;
        if (ifc.use_rs1 && cnt_of(int'(ifc.issue_rs1)) > FS) s = 1'b1;
        if (ifc.use_rs2 && cnt_of(int'(ifc.issue_rs2)) > FS) s = 1'b1;
        if (ifc.use_rs3 && cnt_of(int'(ifc.issue_rs3)) > FS) s = 1'b1;
        if (ifc.issue_wr) begin
            if (cnt_of(int'(ifc.issue_rd)) > L) s = 1'b1;
            foreach (pend[i]) if (pend[i].rem == L) s = 1'b1;
        end
        return s;
    endfunction

    function automatic bit m_fire();
        return ifc.issue_valid && !m_stall() && clken && !flush;
    endfunction

    always @(posedge clk or negedge rstn) begin : model
        bit    f;
        bit    ok;
        int    L;
        pend_t nq [$];
        if (!rstn) begin
            pend.delete();
            lat_err_m = 1'b0;
        end else if (clken) begin
            f  = m_fire();
            L  = int'(ifc.issue_lat);
            ok = (L >= 1) && (L <= ML);
            if (flush) begin
                pend.delete();
                lat_err_m = 1'b0;
            end else begin
                nq.delete();
                foreach (pend[i]) begin
                    if (pend[i].rem > 0) nq.push_back('{pend[i].rem - 1, pend[i].rd});
                end
                if (f && ifc.issue_wr && ok) nq.push_back('{L - 1, int'(ifc.issue_rd)});
                pend = nq;
                lat_err_m = f && ifc.issue_wr && !ok;
            end
        end
    end

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        bit          ew;
        int          erd;
        logic [31:0] eb;
        if (chk_on) begin
            ew  = 1'b0;
            erd = 0;
            foreach (pend[i]) begin
                if (pend[i].rem == 0) begin
                    ew  = 1'b1;
                    erd = pend[i].rd;
                end
            end
            eb = '0;
            for (int r = 0; r < 32; r++) eb[r] = cnt_of(r) != 0;
            check("stall", 32'(ifc.stall), 32'(m_stall()));
            check("issue_fire", 32'(ifc.issue_fire), 32'(m_fire()));
            check("wb_valid", 32'(wb_valid), 32'(ew));
            if (ew) check("wb_rd", 32'(wb_rd), 32'(erd));
            check("busy_mask", busy_mask, eb);
            check("inflight", 32'(inflight), 32'(pend.size()));
            check("lat_err", 32'(lat_err), 32'(lat_err_m));
        end
    end

    task automatic idle();
        ifc.issue_valid = 1'b0;
        ifc.issue_rs1   = '0;
        ifc.issue_rs2   = '0;
        ifc.issue_rs3   = '0;
        ifc.use_rs1     = 1'b0;
        ifc.use_rs2     = 1'b0;
        ifc.use_rs3     = 1'b0;
        ifc.issue_wr    = 1'b0;
        ifc.issue_rd    = '0;
        ifc.issue_lat   = '0;
    endtask

    task automatic put(int rd, int lat);
        idle();
        ifc.issue_valid = 1'b1;
        ifc.issue_wr    = 1'b1;
        ifc.issue_rd    = reg_idx_t'(rd);
        ifc.issue_lat   = lat_t'(lat);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int r;
        tests = 0;
        fails = 0;
        idle();
        clken = 1'b1;
        flush = 1'b0;
        rstn  = 1'b0;
        tick();
        chk_on = 1'b1;
        #1;
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_inflight", 32'(inflight), 0);
        check("rst_busy", busy_mask, 0);
        check("rst_lat_err", 32'(lat_err), 0);
        check("rst_stall", 32'(ifc.stall), 0);
        tick();
        rstn = 1'b1;

        // RAW: rd=3 L=4, reader of f3 waits three cycles
        put(3, 4);
        #1 check("raw_fire0", 32'(ifc.issue_fire), 1);
        tick();
        idle();
        ifc.issue_valid = 1'b1;
        ifc.use_rs1     = 1'b1;
        ifc.issue_rs1   = 5'd3;
        repeat (3) begin
            #1 check("raw_stall", 32'(ifc.stall), 1);
            tick();
        end
        #1;
        check("raw_fire", 32'(ifc.issue_fire), 1);
        check("raw_wb", 32'(wb_valid), 1);
        check("raw_wb_rd", 32'(wb_rd), 3);
        tick();
        idle();
        repeat (8) tick();

        // Port conflict: second write wants the same writeback slot
        put(1, 4);
        tick();
        put(2, 3);
        #1 check("port_stall", 32'(ifc.stall), 1);
        tick();
        #1 check("port_fire", 32'(ifc.issue_fire), 1);
        tick();
        idle();
        #1 check("port_inflight", 32'(inflight), 2);
        tick();
        #1 check("port_wb1", {27'd0, wb_rd}, 1);
        tick();
        #1 check("port_wb2", {26'd0, wb_valid, wb_rd}, 32'h22);
        repeat (8) tick();

        // WAW on f5: L=6 then L=1 waits until the older one is at 1
        put(5, 6);
        tick();
        put(5, 1);
        repeat (5) begin
            #1 check("waw_stall", 32'(ifc.stall), 1);
            tick();
        end
        #1;
        check("waw_fire", 32'(ifc.issue_fire), 1);
        check("waw_wb_old", 32'(wb_valid), 1);
        tick();
        idle();
        #1 check("waw_wb_new", {26'd0, wb_valid, wb_rd}, 32'h25);
        repeat (8) tick();

        // Illegal latency
        put(7, 0);
        #1 check("lat0_fire", 32'(ifc.issue_fire), 1);
        tick();
        idle();
        #1;
        check("lat0_err", 32'(lat_err), 1);
        check("lat0_busy", busy_mask, 0);
        tick();
        #1 check("lat0_pulse", 32'(lat_err), 0);
        repeat (2) tick();

        // Flush with three writes in flight
        put(8, 5);
        tick();
        put(9, 5);
        tick();
        put(10, 5);
        tick();
        idle();
        #1;
        check("fl_inflight", 32'(inflight), 3);
        check("fl_busy", busy_mask, 32'h0000_0700);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("fl_busy0", busy_mask, 0);
        check("fl_inflight0", 32'(inflight), 0);
        repeat (6) begin
            #1 check("fl_no_wb", 32'(wb_valid), 0);
            tick();
        end

        // Asynchronous reset mid-run, then immediate legal issue
        put(11, 6);
        tick();
        put(12, 3);
        tick();
        idle();
        #1 rstn = 1'b0;
        #1;
        check("ar_wb", 32'(wb_valid), 0);
        check("ar_inflight", 32'(inflight), 0);
        check("ar_busy", busy_mask, 0);
        check("ar_lat_err", 32'(lat_err), 0);
        check("ar_stall", 32'(ifc.stall), 0);
        rstn = 1'b1;
        put(11, 6);
        #1 check("ar_refire", 32'(ifc.issue_fire), 1);
        tick();
        idle();
        repeat (8) tick();

        // clken low for three cycles delays an L=2 writeback by three
        put(13, 2);
        tick();
        idle();
        ifc.issue_valid = 1'b1;
        clken = 1'b0;
        repeat (3) begin
            #1;
            check("ce_wb", 32'(wb_valid), 0);
            check("ce_fire", 32'(ifc.issue_fire), 0);
            tick();
        end
        clken = 1'b1;
        idle();
        #1 check("ce_wb_late", 32'(wb_valid), 0);
        tick();
        #1 check("ce_wb_now", {26'd0, wb_valid, wb_rd}, 32'h2d);
        repeat (4) tick();

        // Random traffic on a small register window to provoke hazards
        for (int c = 0; c < 4000; c++) begin
            rstn            = ($urandom % 500) != 0;
            clken           = ($urandom % 10) != 0;
            flush           = ($urandom % 40) == 0;
            ifc.issue_valid = ($urandom % 10) < 7;
            ifc.issue_rs1   = reg_idx_t'($urandom % 8);
            ifc.issue_rs2   = reg_idx_t'($urandom % 8);
            ifc.issue_rs3   = reg_idx_t'($urandom % 8);
            ifc.use_rs1     = 1'($urandom % 2);
            ifc.use_rs2     = 1'($urandom % 2);
            ifc.use_rs3     = 1'($urandom % 2);
            ifc.issue_wr    = ($urandom % 5) != 0;
            ifc.issue_rd    = reg_idx_t'($urandom % 8);
            r = int'($urandom % 16);
            if (r == 0) ifc.issue_lat = 3'd0;
            else if (r == 1) ifc.issue_lat = 3'd7;
            else ifc.issue_lat = lat_t'(1 + (r % ML));
            tick();
        end
        rstn  = 1'b1;
        clken = 1'b1;
        flush = 1'b0;
        idle();
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
